// File: rtl/dense_stream_fc.sv
// dense_stream_fc
// Fully-connected output stage: accumulates one frame of pooled samples
// against OUT_N runtime-programmable weight vectors in parallel, then
// presents OUT_N biased, rescaled and saturated scores over valid/ready.
module dense_stream_fc #(
   parameter int DATA_W = 8,
   parameter int FRAC   = 4,
   parameter int IN_N   = 16,
   parameter int OUT_N  = 4,
   parameter int ACC_W  = 24,
   parameter int W_AW   = 6,
   parameter int B_AW   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     w_we,
   input  logic [W_AW-1:0]          w_addr,
   input  logic signed [DATA_W-1:0] w_data,
   input  logic                     b_we,
   input  logic [B_AW-1:0]          b_addr,
   input  logic signed [DATA_W-1:0] b_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic [B_AW-1:0]          out_idx,
   output logic                     in_drop,
   output logic                     busy
);

   localparam int CNT_W = (IN_N > 1) ? $clog2(IN_N) : 1;
   localparam int W_N   = IN_N * OUT_N;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_N - 1);
   localparam logic [B_AW-1:0]  IDX_LAST = B_AW'(OUT_N - 1);
   localparam logic [W_AW:0]    W_DEPTH  = (W_AW + 1)'(W_N);
   localparam logic [B_AW:0]    B_DEPTH  = (B_AW + 1)'(OUT_N);

   // Saturation bounds expressed at accumulator width; the minimum is the
   // bitwise complement of the maximum in two's complement.
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
   localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

   typedef enum logic {ACCUM, EMIT} state_t;

   state_t                   r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic signed [DATA_W-1:0] r_w [W_N];
   logic signed [DATA_W-1:0] r_b [OUT_N];
   logic signed [ACC_W-1:0]  r_acc [OUT_N];
   logic                     r_out_valid;
   logic [B_AW-1:0]          r_out_idx;
   logic                     r_in_drop;

   logic signed [2*DATA_W-1:0] w_prod [OUT_N];
   logic signed [ACC_W-1:0]    w_bias_ext;
   logic signed [ACC_W-1:0]    w_biased;
   logic signed [ACC_W-1:0]    w_scaled;

   // Weight and bias register file; writes land in any state and
   // out-of-range addresses are silently dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < W_N; k++) r_w[k] <= '0;
         for (int k = 0; k < OUT_N; k++) r_b[k] <= '0;
      end else begin
         if (w_we && ({1'b0, w_addr} < W_DEPTH)) r_w[w_addr] <= w_data;
         if (b_we && ({1'b0, b_addr} < B_DEPTH)) r_b[b_addr] <= b_data;
      end
   end

   // Full-precision products of the current sample with each neuron's weight
   // at the current input position (weight index = j*IN_N + cnt).
   always_comb begin
      for (int j = 0; j < OUT_N; j++) begin
         w_prod[j] = in_data * r_w[W_AW'(j * IN_N) + W_AW'(r_cnt)];
      end
   end

   // Frame control: accumulate IN_N samples, then hand results out one per
   // transfer; the final transfer clears the accumulators for the next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ACCUM;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_in_drop   <= 1'b0;
         for (int j = 0; j < OUT_N; j++) r_acc[j] <= '0;
      end else begin
         r_in_drop <= 1'b0;
         case (r_state)
            ACCUM: begin
               if (in_valid) begin
                  for (int j = 0; j < OUT_N; j++) begin
                     r_acc[j] <= r_acc[j] +
                        {{(ACC_W - 2 * DATA_W){w_prod[j][2*DATA_W-1]}}, w_prod[j]};
                  end
                  if (r_cnt == CNT_LAST) begin
                     r_cnt       <= '0;
                     r_state     <= EMIT;
                     r_out_valid <= 1'b1;
                     r_out_idx   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            EMIT: begin
               r_in_drop <= in_valid;
               if (out_ready) begin
                  if (r_out_idx == IDX_LAST) begin
                     r_state     <= ACCUM;
                     r_out_valid <= 1'b0;
                     r_out_idx   <= '0;
                     r_cnt       <= '0;
                     for (int j = 0; j < OUT_N; j++) r_acc[j] <= '0;
                  end else begin
                     r_out_idx <= r_out_idx + 1'b1;
                  end
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   // Score for the presented neuron: add the bias aligned to the product
   // scale, floor-shift back to Q.FRAC, then clamp to the output range.
   always_comb begin
      w_bias_ext = {{(ACC_W - DATA_W){r_b[r_out_idx][DATA_W-1]}}, r_b[r_out_idx]};
      w_biased   = r_acc[r_out_idx] + (w_bias_ext <<< FRAC);
      w_scaled   = w_biased >>> FRAC;
      if (!r_out_valid) begin
         out_data = '0;
      end else if (w_scaled > SAT_MAX) begin
         out_data = OUT_MAX;
      end else if (w_scaled < SAT_MIN) begin
         out_data = OUT_MIN;
      end else begin
         out_data = w_scaled[DATA_W-1:0];
      end
   end

   assign out_valid = r_out_valid;
   assign out_idx   = r_out_idx;
   assign in_drop   = r_in_drop;
   assign busy      = (r_state == EMIT);

endmodule

// File: tb/tb_dense_stream_fc.sv
// Testbench for dense_stream_fc: directed frames with hand-computed scores.
module tb_dense_stream_fc;

   localparam int DATA_W = 8;
   localparam int FRAC   = 4;
   localparam int IN_N   = 16;
   localparam int OUT_N  = 4;
   localparam int ACC_W  = 24;
   localparam int W_AW   = 6;
   localparam int B_AW   = 2;

   typedef int scoreArr_t [OUT_N];

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     w_we;
   logic [W_AW-1:0]          w_addr;
   logic signed [DATA_W-1:0] w_data;
   logic                     b_we;
   logic [B_AW-1:0]          b_addr;
   logic signed [DATA_W-1:0] b_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;
   logic [B_AW-1:0]          out_idx;
   logic                     in_drop;
   logic                     busy;

   int testsRun    = 0;
   int testsFailed = 0;

   dense_stream_fc #(
      .DATA_W(DATA_W), .FRAC(FRAC), .IN_N(IN_N), .OUT_N(OUT_N),
      .ACC_W(ACC_W), .W_AW(W_AW), .B_AW(B_AW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx),
      .in_drop(in_drop), .busy(busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // One input sample on the next negedge; the following posedge consumes it.
   task automatic applyStimulus(input int value);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DATA_W'(value);
   endtask

   // Every weight and bias set to a single value.
   task automatic programAll(input int wVal, input int bVal);
      for (int a = 0; a < IN_N * OUT_N; a++) begin
         @(negedge clk);
         w_we   = 1'b1;
         w_addr = W_AW'(a);
         w_data = DATA_W'(wVal);
         b_we   = (a < OUT_N);
         b_addr = B_AW'(a);
         b_data = DATA_W'(bVal);
      end
      @(negedge clk);
      w_we = 1'b0;
      b_we = 1'b0;
   endtask

   // Full frame; returns at the negedge right after the last sample edge.
   task automatic sendFrame(input int value, input int count);
      for (int i = 0; i < count; i++) applyStimulus(value);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Drains the EMIT phase, checking index order and scores on each transfer.
   task automatic emitCheck(input string tag, input scoreArr_t expv, input bit alternate);
      int  seen   = 0;
      int  cycles = 0;
      bit  rdy;
      checkOutput({tag, " valid on entry"}, int'(out_valid), 1);
      checkOutput({tag, " busy on entry"}, int'(busy), 1);
      while (seen < OUT_N && cycles < 50) begin
         rdy = alternate ? ((cycles % 2) == 0) : 1'b1;
         out_ready = rdy;
         if (out_valid && rdy) begin
            checkOutput($sformatf("%s idx%0d", tag, seen), int'(out_idx), seen);
            checkOutput($sformatf("%s data%0d", tag, seen), int'(out_data), expv[seen]);
            seen++;
         end
         cycles++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      checkOutput({tag, " transfers"}, seen, OUT_N);
      if (!alternate) checkOutput({tag, " emit cycles"}, cycles, OUT_N);
      checkOutput({tag, " valid after"}, int'(out_valid), 0);
      checkOutput({tag, " busy after"}, int'(busy), 0);
   endtask

   // Bound on total run time.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios
   initial begin
      scoreArr_t s72  = '{72, 72, 72, 72};
      scoreArr_t sNeg = '{-128, -128, -128, -128};
      scoreArr_t sPos = '{127, 127, 127, 127};
      scoreArr_t sFlr = '{0, 0, -1, 0};
      scoreArr_t sZer = '{0, 0, 0, 0};

      rst = 1'b0; in_valid = 1'b0; in_data = '0;
      w_we = 1'b0; w_addr = '0; w_data = '0;
      b_we = 1'b0; b_addr = '0; b_data = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_data", int'(out_data), 0);
      checkOutput("reset out_idx", int'(out_idx), 0);
      checkOutput("reset in_drop", int'(in_drop), 0);
      checkOutput("reset busy", int'(busy), 0);
      rst = 1'b1;

      // Basic frame: 16 * (0.25*1.0) + 0.5 = 4.5
      programAll(16, 8);
      sendFrame(4, IN_N);
      emitCheck("basic", s72, 1'b0);

      // Saturation both ways
      programAll(-16, 0);
      sendFrame(16, IN_N);
      emitCheck("satneg", sNeg, 1'b0);
      programAll(16, 0);
      sendFrame(16, IN_N);
      emitCheck("satpos", sPos, 1'b0);

      // Floor rounding: neuron 2, input 5 weight = 1 LSB, inputs = -1 LSB
      programAll(0, 0);
      @(negedge clk);
      w_we = 1'b1; w_addr = W_AW'(2 * IN_N + 5); w_data = 8'sd1;
      @(negedge clk);
      w_we = 1'b0;
      sendFrame(-1, IN_N);
      emitCheck("floor", sFlr, 1'b0);

      // Backpressure with a bias write while held
      programAll(16, 8);
      sendFrame(4, IN_N);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("hold%0d valid", k), int'(out_valid), 1);
         checkOutput($sformatf("hold%0d idx", k), int'(out_idx), 0);
         checkOutput($sformatf("hold%0d data", k), int'(out_data), 72);
         @(negedge clk);
      end
      b_we = 1'b1; b_addr = '0; b_data = 8'sd24;
      @(negedge clk);
      b_we = 1'b0;
      checkOutput("bias write visible", int'(out_data), 88);
      b_we = 1'b1; b_addr = '0; b_data = 8'sd8;
      @(negedge clk);
      b_we = 1'b0;
      checkOutput("bias restore", int'(out_data), 72);
      emitCheck("alternate", s72, 1'b1);

      // Sample arriving during EMIT is dropped
      sendFrame(4, IN_N);
      in_valid = 1'b1;
      in_data  = 8'sd100;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("drop pulse", int'(in_drop), 1);
      checkOutput("drop idx", int'(out_idx), 0);
      checkOutput("drop data", int'(out_data), 72);
      @(negedge clk);
      checkOutput("drop single cycle", int'(in_drop), 0);
      emitCheck("afterdrop", s72, 1'b0);
      sendFrame(4, IN_N);
      emitCheck("nextframe", s72, 1'b0);

      // Reset mid-frame, reprogram, full frame
      for (int i = 0; i < 7; i++) applyStimulus(4);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      programAll(16, 8);
      sendFrame(4, IN_N);
      emitCheck("postreset", s72, 1'b0);

      // Reset mid-EMIT clears outputs and the weight/bias store
      sendFrame(4, IN_N);
      rst = 1'b0;
      #1;
      checkOutput("emit abort valid", int'(out_valid), 0);
      checkOutput("emit abort busy", int'(busy), 0);
      checkOutput("emit abort data", int'(out_data), 0);
      @(negedge clk);
      rst = 1'b1;
      sendFrame(4, IN_N);
      emitCheck("clearedmem", sZer, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
